sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, is the number of clock cycles each SRAM half-word phase is held; legal range is 1..15.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 mem_read  in  1  load request from the memory stage, held stable while ready=0.
REQ-005 mem_write  in  1  store request from the memory stage, held stable while ready=0.
REQ-006 address  in  32  byte address of the access; word-aligned, bits [1:0] ignored.
REQ-007 write_data  in  32  store data.
REQ-008 read_data  out  32  load result.
REQ-009 ready  out  1  0 = freeze the pipeline; 1 = the access is complete or no access is requested.
REQ-010 sram_addr  out  18  SRAM half-word address.
REQ-011 sram_we_n  out  1  SRAM write enable, active-low.
REQ-012 sram_dq_out  out  16  data driven onto the SRAM bus.
REQ-013 sram_dq_oe  out  1  1 = the controller drives the SRAM data bus.
REQ-014 sram_dq_in  in  16  data sampled from the SRAM bus.

Function
REQ-015 The FSM has four states: IDLE, LO, HI and DONE.
REQ-016 IDLE transitions:
- Request seen (mem_read|mem_write=1): latch address, write_data and the direction, then go to LO.
- No request: stay in IDLE.
REQ-017 A wait counter runs in LO and HI.
- LO -> HI after WAIT_CYCLES cycles.
- HI -> DONE after WAIT_CYCLES cycles.
- DONE -> IDLE unconditionally.
REQ-018 ready is combinational:
- 1 in IDLE with no request, and 1 in DONE.
- 0 in IDLE with a request, and 0 in LO and HI.
REQ-019 Latency: a request first seen in IDLE at cycle T gives ready=1 at cycle T+2*WAIT_CYCLES+1 for exactly one cycle.
REQ-020 sram_addr addressing:
- In LO: {latched_address[18:2], 1'b0}.
- In HI: {latched_address[18:2], 1'b1}.
- In IDLE and DONE: 0.
REQ-021 Write access:
- sram_we_n=0 and sram_dq_oe=1 throughout LO and HI.
- sram_dq_out = write_data[15:0] in LO and write_data[31:16] in HI.
REQ-022 Read access:
- sram_we_n=1 and sram_dq_oe=0.
- sram_dq_in is sampled on the last LO cycle into read_data[15:0], and on the last HI cycle into read_data[31:16].
REQ-023 read_data holds its value until the next read updates it; writes do not modify read_data.
REQ-024 Outside LO and HI, sram_we_n=1, sram_dq_oe=0 and sram_dq_out=0.
REQ-025 If mem_read and mem_write are both 1, the controller performs a write.
REQ-026 Request changes after the IDLE sample are ignored until the next IDLE.
REQ-027 A request still asserted in DONE does not restart the access; the next access begins only when a request is seen in IDLE.

Reset
REQ-028 While rst=1, the block forces:
- state=IDLE, counter=0, read_data=0;
- sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0;
- ready follows REQ-018 from the request inputs.
REQ-029 Reset asserted mid-access aborts the access immediately, releases the SRAM bus asynchronously, and leaves no partial update visible in read_data.

Structure
REQ-030 The shared package arm_pkg holds:
- the FSM state encoding;
- the WAIT_CYCLES default;
- the SRAM address width (18) and data width (16).
REQ-031 The wait counter is a sub-module sram_wait_counter with ports clk, rst, clear and enable, and a terminal-count output.

Verification
REQ-032 Read, WAIT_CYCLES=2: mem_read=1, address=0x0000_0408, SRAM half-words 0x1234 (lo) and 0xABCD (hi) -> ready=0 for 5 cycles, then 1; read_data=0xABCD1234; sram_addr steps 0x00204 then 0x00205.
REQ-033 Write: mem_write=1, address=0x10, write_data=0xDEAD_BEEF -> sram_we_n=0 for 4 cycles; sram_dq_out=0xBEEF at sram_addr=0x00008, then 0xDEAD at 0x00009; read_data unchanged.
REQ-034 Simultaneous requests: mem_read=mem_write=1 -> write performed, sram_dq_oe=1, read_data unchanged.
REQ-035 Back-to-back accesses: a read completes, then a new write is presented in the cycle after DONE -> a second full 5-cycle freeze with no duplicated or skipped access.
REQ-036 Reset mid-access: rst asserted in HI during a read -> sram_we_n=1, sram_dq_oe=0 and read_data=0 immediately; the FSM is in IDLE after rst deasserts.
REQ-037 Latency scaling: with WAIT_CYCLES=1 a read freezes 3 cycles; with WAIT_CYCLES=4 a read freezes 9 cycles.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared SRAM controller FSM encoding, widths and timing defaults
package arm_pkg;

  localparam int WAIT_CYCLES_DEFAULT = 2;
  localparam int SRAM_AW             = 18;
  localparam int SRAM_DW             = 16;
  localparam int WAIT_CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - per-phase wait counter, tc on the last cycle of a phase
module sram_wait_counter
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = enable && (cnt_q == WAIT_CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit memory-stage access split into two 16-bit SRAM phases
module sram_controller
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in
);

  sram_state_e        state_q, state_d;
  logic [16:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               is_write_q, is_write_d;
  logic [SRAM_DW-1:0] rd_lo_q, rd_lo_d;
  logic [31:0]        read_data_q, read_data_d;

  logic req;
  logic in_phase;
  logic phase_tc;
  logic addr_unused;

  assign req         = mem_read | mem_write;
  assign in_phase    = (state_q == LO) || (state_q == HI);
  assign addr_unused = ^{address[31:19], address[1:0]};

  // Clearing on tc restarts the count for the following phase.
  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (phase_tc || !in_phase),
    .enable(in_phase),
    .tc    (phase_tc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    rd_lo_d     = rd_lo_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d     = address[18:2];
          wdata_d    = write_data;
          is_write_d = mem_write;
          state_d    = LO;
        end
      end
      LO: begin
        if (phase_tc) begin
          if (!is_write_q) begin
            rd_lo_d = sram_dq_in;
          end
          state_d = HI;
        end
      end
      HI: begin
        // Low half is staged so read_data only ever changes as a whole word.
        if (phase_tc) begin
          if (!is_write_q) begin
            read_data_d = {sram_dq_in, rd_lo_q};
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      rd_lo_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      rd_lo_q     <= rd_lo_d;
      read_data_q <= read_data_d;
    end
  end

  // Bus outputs decode straight from state, so reset releases them without a clock.
  always_comb begin
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    case (state_q)
      LO: begin
        sram_addr = {addr_q, 1'b0};
        if (is_write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end
      end
      HI: begin
        sram_addr = {addr_q, 1'b1};
        if (is_write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end
      end
      default: begin
        sram_addr = '0;
      end
    endcase
  end

  assign ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign read_data = read_data_q;

endmodule
